// File: rtl/reg8088_pkg.sv
// Shared 8088 register-file definitions: opcodes, register indices, sequencer
// state encoding and the 8-bit operand extraction helper.
package reg8088_pkg;

   localparam logic [1:0] OP_MOV  = 2'd0;
   localparam logic [1:0] OP_XCHG = 2'd1;
   localparam logic [1:0] OP_LDI  = 2'd2;
   localparam logic [1:0] OP_READ = 2'd3;

   localparam logic [2:0] REG_AX = 3'd0;
   localparam logic [2:0] REG_BX = 3'd1;
   localparam logic [2:0] REG_CX = 3'd2;
   localparam logic [2:0] REG_DX = 3'd3;
   localparam logic [2:0] REG_SP = 3'd4;
   localparam logic [2:0] REG_BP = 3'd5;
   localparam logic [2:0] REG_SI = 3'd6;
   localparam logic [2:0] REG_DI = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WR1  = 3'd2,
      S_WR2  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   function automatic logic [7:0] byte_extract(input logic [15:0] v, input logic hi);
      return hi ? v[15:8] : v[7:0];
   endfunction

endpackage

// File: rtl/reg_xfer_ctrl_8088.sv
// Register-transfer sequencer: runs MOV/XCHG/LDI/READ as fixed read/write
// micro-sequences on the 8088 register bank ports.
module reg_xfer_ctrl_8088
   import reg8088_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [2:0]  cmd_dst,
   input  logic [2:0]  cmd_src,
   input  logic        cmd_size,
   input  logic        cmd_dst_hi,
   input  logic        cmd_src_hi,
   input  logic [15:0] cmd_imm,
   output logic        rsp_done,
   output logic        rsp_err,
   output logic [15:0] rsp_data,
   output logic        rb_en_write,
   output logic [2:0]  rb_reg_write,
   output logic [15:0] rb_write_data,
   output logic        rb_size,
   output logic        rb_select_high_low,
   output logic [2:0]  rb_reg_read1,
   output logic [2:0]  rb_reg_read2,
   input  logic [15:0] rb_read_data1,
   input  logic [15:0] rb_read_data2
);

   state_t      state, state_nxt;
   logic [1:0]  op;
   logic [2:0]  dst, src;
   logic        size, dst_hi, src_hi, err;
   logic [15:0] imm, opa, opb;
   logic        accept, illegal;
   logic [15:0] src_val, dst_val;

   assign accept = cmd_valid && (state == S_IDLE);

   // Only AX..DX have byte halves; READ has no destination, LDI no source.
   assign illegal = !cmd_size &&
                    (((cmd_op != OP_READ) && cmd_dst[2]) ||
                     ((cmd_op != OP_LDI)  && cmd_src[2]));

   assign src_val = size ? opa : {8'h00, byte_extract(opa, src_hi)};
   assign dst_val = size ? opb : {8'h00, byte_extract(opb, dst_hi)};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         op     <= OP_MOV;
         dst    <= '0;
         src    <= '0;
         size   <= 1'b0;
         dst_hi <= 1'b0;
         src_hi <= 1'b0;
         err    <= 1'b0;
         imm    <= '0;
         opa    <= '0;
         opb    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op     <= cmd_op;
            dst    <= cmd_dst;
            src    <= cmd_src;
            size   <= cmd_size;
            dst_hi <= cmd_dst_hi;
            src_hi <= cmd_src_hi;
            imm    <= cmd_imm;
            err    <= illegal;
         end
         if (state == S_RD) begin
            opa <= rb_read_data1;
            opb <= rb_read_data2;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) begin
            if (illegal)             state_nxt = S_DONE;
            else if (cmd_op == OP_LDI) state_nxt = S_WR1;
            else                     state_nxt = S_RD;
         end
         S_RD:   state_nxt = (op == OP_READ) ? S_DONE : S_WR1;
         S_WR1:  state_nxt = (op == OP_XCHG) ? S_WR2 : S_DONE;
         S_WR2:  state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready          = 1'b0;
      rsp_done           = 1'b0;
      rsp_err            = 1'b0;
      rsp_data           = '0;
      rb_en_write        = 1'b0;
      rb_reg_write       = '0;
      rb_write_data      = '0;
      rb_size            = 1'b0;
      rb_select_high_low = 1'b0;
      rb_reg_read1       = '0;
      rb_reg_read2       = '0;
      case (state)
         S_IDLE: cmd_ready = 1'b1;
         S_RD: begin
            rb_reg_read1 = src;
            rb_reg_read2 = dst;
         end
         S_WR1: begin
            rb_en_write        = 1'b1;
            rb_reg_write       = dst;
            rb_size            = size;
            rb_select_high_low = dst_hi;
            if (op == OP_LDI) rb_write_data = size ? imm : {8'h00, imm[7:0]};
            else              rb_write_data = src_val;
         end
         // Writes back the copy of dst taken in RD, so src==dst swaps correctly.
         S_WR2: begin
            rb_en_write        = 1'b1;
            rb_reg_write       = src;
            rb_size            = size;
            rb_select_high_low = src_hi;
            rb_write_data      = dst_val;
         end
         S_DONE: begin
            rsp_done = 1'b1;
            rsp_err  = err;
            if ((op == OP_READ) && !err) rsp_data = src_val;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_reg_xfer_ctrl_8088.sv
// Directed bench for reg_xfer_ctrl_8088 against a behavioural register bank.
module tb_reg_xfer_ctrl_8088;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = '0;
   logic [2:0]  cmd_dst = '0, cmd_src = '0;
   logic        cmd_size = 1'b0, cmd_dst_hi = 1'b0, cmd_src_hi = 1'b0;
   logic [15:0] cmd_imm = '0;
   logic        rsp_done, rsp_err;
   logic [15:0] rsp_data;
   logic        rb_en_write, rb_size, rb_select_high_low;
   logic [2:0]  rb_reg_write, rb_reg_read1, rb_reg_read2;
   logic [15:0] rb_write_data, rb_read_data1, rb_read_data2;

   always #5 clk = ~clk;

   reg_xfer_ctrl_8088 dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src),
      .cmd_size(cmd_size), .cmd_dst_hi(cmd_dst_hi), .cmd_src_hi(cmd_src_hi),
      .cmd_imm(cmd_imm),
      .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_data(rsp_data),
      .rb_en_write(rb_en_write), .rb_reg_write(rb_reg_write),
      .rb_write_data(rb_write_data), .rb_size(rb_size),
      .rb_select_high_low(rb_select_high_low),
      .rb_reg_read1(rb_reg_read1), .rb_reg_read2(rb_reg_read2),
      .rb_read_data1(rb_read_data1), .rb_read_data2(rb_read_data2)
   );

   // behavioural register bank
   logic [15:0] bank [8];
   int          wr_total = 0;
   initial for (int i = 0; i < 8; i++) bank[i] = 16'h0000;
   assign rb_read_data1 = bank[rb_reg_read1];
   assign rb_read_data2 = bank[rb_reg_read2];
   always @(posedge clk) begin
      if (rb_en_write) begin
         wr_total <= wr_total + 1;
         if (rb_size)                 bank[rb_reg_write]        <= rb_write_data;
         else if (rb_select_high_low) bank[rb_reg_write][15:8] <= rb_write_data[7:0];
         else                         bank[rb_reg_write][7:0]  <= rb_write_data[7:0];
      end
   end

   int checks = 0, failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // results of the last command
   int          done_cyc, wr_n;
   int          wr_cyc [2];
   logic [2:0]  wr_reg [2];
   logic [15:0] wr_dat [2];
   logic        r_err;
   logic [15:0] r_data;

   task automatic run_cmd(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] src,
                          input logic sz, input logic dhi, input logic shi, input logic [15:0] imm);
      int wait_n = 0;
      while (!cmd_ready && wait_n < 20) begin
         @(negedge clk);
         wait_n++;
      end
      if (!cmd_ready) chk("ready_timeout", 0, 1);
      cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src;
      cmd_size = sz; cmd_dst_hi = dhi; cmd_src_hi = shi; cmd_imm = imm;
      @(posedge clk);
      #1;
      // scramble fields: the DUT must work from its latched copy
      cmd_valid = 1'b0; cmd_op = ~op; cmd_dst = ~dst; cmd_src = ~src;
      cmd_size = ~sz; cmd_dst_hi = ~dhi; cmd_src_hi = ~shi; cmd_imm = ~imm;
      done_cyc = -1; wr_n = 0; r_err = 1'b0; r_data = '0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (rb_en_write && wr_n < 2) begin
            wr_cyc[wr_n] = c; wr_reg[wr_n] = rb_reg_write; wr_dat[wr_n] = rb_write_data;
            wr_n++;
         end
         if (rsp_done) begin
            done_cyc = c; r_err = rsp_err; r_data = rsp_data;
            break;
         end
      end
      if (done_cyc < 0) chk("done_timeout", 0, 1);
      @(negedge clk);
      chk("ready_after_done", cmd_ready, 1);
   endtask

   initial begin
      // reset state
      #12;
      chk("rst_ready", cmd_ready, 1);
      chk("rst_done", rsp_done, 0);
      chk("rst_wen", rb_en_write, 0);
      chk("rst_data", rsp_data, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // LDI16 AX=1234
      run_cmd(2'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'h1234);
      chk("ldi_wr_n", wr_n, 1);
      chk("ldi_wr_cyc", wr_cyc[0], 1);
      chk("ldi_wr_reg", wr_reg[0], 0);
      chk("ldi_wr_dat", wr_dat[0], 16'h1234);
      chk("ldi_done", done_cyc, 2);
      chk("ldi_err", r_err, 0);
      chk("ldi_rdata", r_data, 0);

      // READ16 AX
      run_cmd(2'd3, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0);
      chk("rd_ax_done", done_cyc, 2);
      chk("rd_ax_data", r_data, 16'h1234);
      chk("rd_ax_wr_n", wr_n, 0);

      // MOV8 BH <- AL
      run_cmd(2'd0, 3'd1, 3'd0, 1'b0, 1'b1, 1'b0, 16'h0);
      chk("mov_done", done_cyc, 3);
      chk("mov_wr_cyc", wr_cyc[0], 2);
      chk("mov_bx", bank[1], 16'h3400);

      // READ8 BH
      run_cmd(2'd3, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 16'h0);
      chk("rd_bh_data", r_data, 16'h0034);

      // XCHG8 AH <-> AL
      run_cmd(2'd1, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 16'h0);
      chk("xchg8_wr_n", wr_n, 2);
      chk("xchg8_wr1_cyc", wr_cyc[0], 2);
      chk("xchg8_wr2_cyc", wr_cyc[1], 3);
      chk("xchg8_done", done_cyc, 4);
      chk("xchg8_ax", bank[0], 16'h3412);

      // XCHG16 SI <-> DI
      run_cmd(2'd2, 3'd6, 3'd0, 1'b1, 1'b0, 1'b0, 16'hBEEF);
      run_cmd(2'd2, 3'd7, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0001);
      run_cmd(2'd1, 3'd6, 3'd7, 1'b1, 1'b0, 1'b0, 16'h0);
      chk("xchg16_wr1", wr_dat[0], 16'h0001);
      chk("xchg16_wr2", wr_dat[1], 16'hBEEF);
      run_cmd(2'd3, 3'd0, 3'd6, 1'b1, 1'b0, 1'b0, 16'h0);
      chk("xchg16_si", r_data, 16'h0001);
      run_cmd(2'd3, 3'd0, 3'd7, 1'b1, 1'b0, 1'b0, 16'h0);
      chk("xchg16_di", r_data, 16'hBEEF);

      // illegal: LDI8 SP
      run_cmd(2'd2, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0, 16'h00AA);
      chk("ill_ldi_done", done_cyc, 1);
      chk("ill_ldi_err", r_err, 1);
      chk("ill_ldi_wr_n", wr_n, 0);
      chk("ill_ldi_sp", bank[4], 16'h0000);

      // illegal: READ8 from DI
      run_cmd(2'd3, 3'd0, 3'd7, 1'b0, 1'b0, 1'b0, 16'h0);
      chk("ill_rd_err", r_err, 1);
      chk("ill_rd_data", r_data, 0);

      // reset during XCHG16 AX<->BX WR1
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_dst = 3'd0; cmd_src = 3'd1;
      cmd_size = 1'b1; cmd_dst_hi = 1'b0; cmd_src_hi = 1'b0;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_wr1", rb_en_write, 1);
      begin
         int wr_before;
         bit saw_done;
         wr_before = wr_total;
         saw_done = 1'b0;
         reset = 1'b0;
         #1;
         chk("rst_mid_wen", rb_en_write, 0);
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rsp_done) saw_done = 1'b1;
         end
         reset = 1'b1;
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rsp_done) saw_done = 1'b1;
         end
         chk("rst_mid_no_done", saw_done, 0);
         chk("rst_mid_no_wr", wr_total - wr_before, 0);
         chk("rst_mid_ready", cmd_ready, 1);
         chk("rst_mid_ax", bank[0], 16'h3412);
         chk("rst_mid_bx", bank[1], 16'h3400);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
